// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on the accept edge; MUL/DIV iterate W steps in BUSY.
module alu_seq #(
    parameter int W   = 8,
    parameter int SHW = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [3:0]   OP,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] Out,
    output logic [W-1:0] OutHi,
    output logic         Zero,
    output logic         Carry,
    output logic         DivZero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    state_t         state;
    logic [SHW-1:0] cnt;
    logic [3:0]     op_p0;
    logic [W-1:0]   a_p0;
    logic [W-1:0]   b_p0;
    logic [W-1:0]   hi_p0;
    logic [W-1:0]   lo_p0;

    logic [W:0]     res;
    logic [W:0]     mul_sum;
    logic [W:0]     div_sh;
    logic [W-1:0]   div_diff;
    logic           div_ge;
    logic [W-1:0]   hi_n;
    logic [W-1:0]   lo_n;

    // Bit W carries ADD carry-out / SUB borrow; it is zero for every other op.
    function automatic logic [W:0] single_op(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] r;
        r = '0;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, a} - {1'b0, b};
            4'd2:    r = {1'b0, a & b};
            4'd3:    r = {1'b0, a | b};
            4'd4:    r = {1'b0, a ^ b};
            4'd5:    r[0] = ^a;
            4'd6:    r = {1'b0, a << b[SHW-1:0]};
            4'd7:    r = {1'b0, a >> b[SHW-1:0]};
            4'd8:    r[0] = (a == b);
            4'd9:    r[0] = (a < b);
            4'd12:   r = {1'b0, a};
            4'd13:   r = {1'b0, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        res      = single_op(OP, InputA, InputB);
        mul_sum  = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, a_p0} : '0);
        div_sh   = {hi_p0, lo_p0[W-1]};
        div_ge   = (div_sh >= {1'b0, b_p0});
        div_diff = div_sh[W-1:0] - b_p0;
        hi_n     = '0;
        lo_n     = '0;
        if (op_p0 == OP_MUL) begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_p0[W-1:1]};
        end else begin
            // Restoring division; B==0 always "fits", giving all-ones quotient and remainder A.
            hi_n = div_ge ? div_diff : div_sh[W-1:0];
            lo_n = {lo_p0[W-2:0], div_ge};
        end
    end

    // Operand latch and iterative working registers (data only, no reset needed).
    always_ff @(posedge Clk) begin
        if (state == IDLE && InValid) begin
            op_p0 <= OP;
            a_p0  <= InputA;
            b_p0  <= InputB;
            hi_p0 <= '0;
            lo_p0 <= (OP == OP_MUL) ? InputB : InputA;
        end else if (state == BUSY) begin
            hi_p0 <= hi_n;
            lo_p0 <= lo_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            Out      <= '0;
            OutHi    <= '0;
            Zero     <= 1'b1;
            Carry    <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        InReady <= 1'b0;
                        cnt     <= '0;
                        if (OP == OP_MUL || OP == OP_DIV) begin
                            state <= BUSY;
                        end else begin
                            state    <= DONE;
                            OutValid <= 1'b1;
                            Out      <= res[W-1:0];
                            OutHi    <= '0;
                            Zero     <= (res[W-1:0] == '0);
                            Carry    <= res[W];
                            DivZero  <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(W - 1)) begin
                        state    <= DONE;
                        OutValid <= 1'b1;
                        Out      <= lo_n;
                        OutHi    <= hi_n;
                        Zero     <= (lo_n == '0);
                        Carry    <= 1'b0;
                        DivZero  <= (op_p0 == OP_DIV) && (b_p0 == '0);
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=8: latency, results, flags, backpressure, reset abort.
module tb_alu_seq;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         InValid = 1'b0;
    logic         OutReady = 1'b0;
    logic [3:0]   OP = '0;
    logic [W-1:0] InputA = '0;
    logic [W-1:0] InputB = '0;
    logic         InReady;
    logic         OutValid;
    logic [W-1:0] Out;
    logic [W-1:0] OutHi;
    logic         Zero;
    logic         Carry;
    logic         DivZero;

    int checks = 0;
    int errors = 0;
    int lat;
    logic seen;

    alu_seq #(.W(W), .SHW(3)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .OP(OP), .InputA(InputA), .InputB(InputB),
        .OutValid(OutValid), .OutReady(OutReady), .Out(Out), .OutHi(OutHi),
        .Zero(Zero), .Carry(Carry), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request; returns edges from accept to first observed OutValid.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int l);
        @(negedge Clk);
        check("in_ready_idle", InReady, 1);
        OP = op; InputA = a; InputB = b; InValid = 1'b1;
        @(posedge Clk);
        l = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            InValid = 1'b0;
            l++;
            if (OutValid) break;
        end
        check("out_valid_seen", OutValid, 1);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] o, input logic [W-1:0] hi,
                             input logic z, input logic c, input logic dz);
        check({tag, "_out"}, Out, o);
        check({tag, "_hi"}, OutHi, hi);
        check({tag, "_zero"}, Zero, z);
        check({tag, "_carry"}, Carry, c);
        check({tag, "_divzero"}, DivZero, dz);
    endtask

    task automatic ack();
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        check("ack_valid_low", OutValid, 0);
        check("ack_ready_high", InReady, 1);
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] o, input logic c);
        int l;
        run_op(op, a, b, l);
        check({tag, "_lat"}, l, 1);
        check_res(tag, o, 8'h00, (o == 8'h00), c, 1'b0);
        ack();
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        check("rst_inready", InReady, 1);
        check("rst_outvalid", OutValid, 0);
        check_res("rst", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

        single("add", 4'd0, 8'hF0, 8'h20, 8'h10, 1'b1);
        single("sub_eq", 4'd1, 8'h05, 8'h05, 8'h00, 1'b0);
        single("sub_brw", 4'd1, 8'h03, 8'h05, 8'hFE, 1'b1);
        single("and", 4'd2, 8'hCA, 8'h0F, 8'h0A, 1'b0);
        single("or", 4'd3, 8'hC0, 8'h05, 8'hC5, 1'b0);
        single("xor", 4'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        single("rxor", 4'd5, 8'h07, 8'h00, 8'h01, 1'b0);
        single("shl_sh0", 4'd6, 8'h5A, 8'h08, 8'h5A, 1'b0);
        single("shr", 4'd7, 8'h80, 8'hFB, 8'h10, 1'b0);
        single("eq", 4'd8, 8'h33, 8'h33, 8'h01, 1'b0);
        single("ltu_t", 4'd9, 8'h03, 8'h05, 8'h01, 1'b0);
        single("ltu_f", 4'd9, 8'h05, 8'h03, 8'h00, 1'b0);
        single("passa", 4'd12, 8'h9C, 8'h11, 8'h9C, 1'b0);
        single("passb", 4'd13, 8'h9C, 8'h11, 8'h11, 1'b0);
        single("op15", 4'd15, 8'hFF, 8'hFF, 8'h00, 1'b0);

        run_op(4'd10, 8'hFF, 8'hFF, lat);
        check("mul_lat", lat, 9);
        check_res("mul", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
        ack();

        run_op(4'd10, 8'h0D, 8'h0B, lat);
        check_res("mul2", 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0);
        ack();

        run_op(4'd11, 8'd100, 8'd7, lat);
        check("div_lat", lat, 9);
        check_res("div", 8'd14, 8'd2, 1'b0, 1'b0, 1'b0);
        ack();

        run_op(4'd11, 8'd9, 8'd0, lat);
        check_res("div0", 8'hFF, 8'd9, 1'b0, 1'b0, 1'b1);
        ack();

        // Backpressure with a competing request held on the input.
        run_op(4'd6, 8'h81, 8'h01, lat);
        check("bp_lat", lat, 1);
        check("bp_out", Out, 8'h02);
        OP = 4'd0; InputA = 8'h01; InputB = 8'h01; InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_hold_out", Out, 8'h02);
            check("bp_hold_valid", OutValid, 1);
            check("bp_hold_inready", InReady, 0);
        end
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        check("bp_ack_valid", OutValid, 0);
        check("bp_ack_inready", InReady, 1);
        @(negedge Clk);
        InValid = 1'b0;
        check("bp_second_valid", OutValid, 1);
        check("bp_second_out", Out, 8'h02);
        check("bp_second_carry", Carry, 0);
        ack();

        // Reset lands on the edge performing MUL step 4.
        @(negedge Clk);
        OP = 4'd10; InputA = 8'hFF; InputB = 8'hFF; InValid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        check("abort_valid", OutValid, 0);
        check("abort_inready", InReady, 1);
        check("abort_out", Out, 8'h00);
        check("abort_zero", Zero, 1);
        check("abort_hi", OutHi, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            seen = seen | OutValid;
        end
        check("abort_no_stale", seen, 0);

        single("post_rst_add", 4'd0, 8'h7F, 8'h01, 8'h80, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
